// File: rtl/mod_reduct_solinas_gen_pkg.sv
// mod_reduct_solinas_gen_pkg: width, offset and latency helpers
// for the generalised Solinas reducer.
package mod_reduct_solinas_gen_pkg;

  localparam int MAX_FOLD = 16;

  function automatic int next_w(
    input int w,
    input int mod_w,
    input int mod_k
  );
    int t;
    t = w - mod_w + mod_k;
    return ((t > mod_w) ? t : mod_w) + 1;
  endfunction

  function automatic int get_fold_nb(
    input int mod_w,
    input int mod_k,
    input int op_w
  );
    int w;
    int n;
    w = op_w;
    n = 0;
    while (w > mod_w + 1 && n < MAX_FOLD) begin
      w = next_w(w, mod_w, mod_k);
      n++;
    end
    return n;
  endfunction

  function automatic int get_fold_w(
    input int i,
    input int mod_w,
    input int mod_k,
    input int op_w
  );
    int w;
    w = op_w;
    for (int j = 0; j < i; j++)
      w = next_w(w, mod_w, mod_k);
    return w;
  endfunction

  // Bit offset of stage i inside the flat per-lane chain vector.
  function automatic int get_chain_off(
    input int i,
    input int mod_w,
    input int mod_k,
    input int op_w
  );
    int o;
    o = 0;
    for (int j = 0; j < i; j++)
      o += get_fold_w(j, mod_w, mod_k, op_w);
    return o;
  endfunction

  function automatic int get_latency(
    input int in_pipe,
    input int mod_w,
    input int mod_k,
    input int op_w
  );
    return in_pipe + get_fold_nb(mod_w, mod_k, op_w) + 1;
  endfunction

endpackage

// File: rtl/mod_reduct_solinas_fold.sv
// mod_reduct_solinas_fold: one lane, one registered fold
// x' = l + h*(2^MOD_K - 1), using 2^MOD_W == 2^MOD_K - 1 (mod M).
module mod_reduct_solinas_fold #(
  parameter int MOD_W = 64,
  parameter int MOD_K = 32,
  parameter int IN_W  = 129,
  parameter int OUT_W = 98
) (
  input  logic             clk,
  input  logic [IN_W-1:0]  x,
  output logic [OUT_W-1:0] y
);

  localparam int HW = IN_W - MOD_W;

  logic [HW-1:0]    h;
  logic [OUT_W-1:0] l_ext;
  logic [OUT_W-1:0] h_ext;
  logic [OUT_W-1:0] sum;

  assign h     = x[IN_W-1:MOD_W];
  assign l_ext = OUT_W'(x[MOD_W-1:0]);
  assign h_ext = OUT_W'(h);
  // l + (h << K) stays below 2^OUT_W, so the subtract never wraps.
  assign sum   = l_ext + (h_ext << MOD_K) - h_ext;

  always_ff @(posedge clk) begin
    y <= sum;
  end

endmodule

// File: rtl/mod_reduct_solinas_gen.sv
// mod_reduct_solinas_gen: pipelined multi-lane reduction mod 2^MOD_W-2^MOD_K+1.
// Define MOD_REDUCT_SOLINAS_GEN_CHECK_EN to compile the simulation checker.
module mod_reduct_solinas_gen #(
  parameter int         MOD_W    = 64,
  parameter int         MOD_K    = MOD_W / 2,
  parameter int         OP_W     = 2 * MOD_W + 1,
  parameter int         LANE_NB  = 1,
  parameter int         IN_PIPE  = 1,
  parameter int         SIDE_W   = 0,
  parameter logic [1:0] RST_SIDE = 2'b00
) (
  input  logic                               clk,
  input  logic                               s_rst_n,
  input  logic [LANE_NB*OP_W-1:0]            a,
  input  logic                               in_avail,
  input  logic [(SIDE_W>0?SIDE_W:1)-1:0]     in_side,
  output logic [LANE_NB*MOD_W-1:0]           z,
  output logic                               out_avail,
  output logic [(SIDE_W>0?SIDE_W:1)-1:0]     out_side
);

  import mod_reduct_solinas_gen_pkg::*;

  localparam int FOLD_NB = get_fold_nb(MOD_W, MOD_K, OP_W);
  localparam int LAT     = get_latency(IN_PIPE, MOD_W, MOD_K, OP_W);
  localparam int SW      = (SIDE_W > 0) ? SIDE_W : 1;
  localparam int CH_W    = get_chain_off(FOLD_NB + 1, MOD_W, MOD_K, OP_W);
  localparam int LST_O   = get_chain_off(FOLD_NB, MOD_W, MOD_K, OP_W);
  localparam int LST_W   = get_fold_w(FOLD_NB, MOD_W, MOD_K, OP_W);
  localparam int XW      = MOD_W + 2;

  localparam logic [XW-1:0] ONE  = XW'(1);
  localparam logic [XW-1:0] M_C  = (ONE << MOD_W) - (ONE << MOD_K) + ONE;
  localparam logic [XW-1:0] M2_C = M_C << 1;

  logic [LAT-1:0] av_q;

  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      av_q <= '0;
    end else begin
      av_q[0] <= in_avail;
      for (int i = 1; i < LAT; i++)
        av_q[i] <= av_q[i-1];
    end
  end

  assign out_avail = av_q[LAT-1];

  if (SIDE_W > 0) begin : g_side
    logic [SW-1:0] sd_q [LAT];

    always_ff @(posedge clk) begin
      if (RST_SIDE[1] && !s_rst_n) begin
        for (int i = 0; i < LAT; i++)
          sd_q[i] <= {SW{RST_SIDE[0]}};
      end else begin
        sd_q[0] <= in_side;
        for (int i = 1; i < LAT; i++)
          sd_q[i] <= sd_q[i-1];
      end
    end

    assign out_side = sd_q[LAT-1];
  end else begin : g_no_side
    logic unused_side;
    assign unused_side = ^in_side;
    assign out_side    = '0;
  end

  for (genvar ln = 0; ln < LANE_NB; ln++) begin : g_lane
    logic [CH_W-1:0]  ch;
    logic [OP_W-1:0]  a_s;
    logic [LST_W-1:0] x_f;
    logic [XW-1:0]    xe;
    logic [MOD_W-1:0] x_lo;
    logic [MOD_W-1:0] z1;
    logic [MOD_W-1:0] z2;
    logic [MOD_W-1:0] z_d;
    logic [MOD_W-1:0] z_q;
    logic             ge1;
    logic             ge2;

    if (IN_PIPE != 0) begin : g_in
      logic [OP_W-1:0] a_q;
      always_ff @(posedge clk) begin
        a_q <= a[ln*OP_W +: OP_W];
      end
      assign a_s = a_q;
    end else begin : g_no_in
      assign a_s = a[ln*OP_W +: OP_W];
    end

    assign ch[OP_W-1:0] = a_s;

    for (genvar f = 0; f < FOLD_NB; f++) begin : g_fold
      localparam int IW = get_fold_w(f, MOD_W, MOD_K, OP_W);
      localparam int OW = get_fold_w(f + 1, MOD_W, MOD_K, OP_W);
      localparam int IO = get_chain_off(f, MOD_W, MOD_K, OP_W);
      localparam int OO = get_chain_off(f + 1, MOD_W, MOD_K, OP_W);

      mod_reduct_solinas_fold #(
        .MOD_W (MOD_W),
        .MOD_K (MOD_K),
        .IN_W  (IW),
        .OUT_W (OW)
      ) u_fold (
        .clk (clk),
        .x   (ch[IO +: IW]),
        .y   (ch[OO +: OW])
      );
    end

    // x < 2^(MOD_W+1) < 3M: at most two subtractions of M.
    assign x_f  = ch[LST_O +: LST_W];
    assign xe   = XW'(x_f);
    assign x_lo = xe[MOD_W-1:0];
    assign ge1  = (xe >= M_C);
    assign ge2  = (xe >= M2_C);
    assign z1   = x_lo - M_C[MOD_W-1:0];
    assign z2   = x_lo - M2_C[MOD_W-1:0];

    always_comb begin
      z_d = x_lo;
      unique case (1'b1)
        ge2:         z_d = z2;
        ge1 && !ge2: z_d = z1;
        default:     z_d = x_lo;
      endcase
    end

    always_ff @(posedge clk) begin
      z_q <= z_d;
    end

    assign z[ln*MOD_W +: MOD_W] = z_q;
  end

`ifdef MOD_REDUCT_SOLINAS_GEN_CHECK_EN
  localparam int CW = (OP_W > XW) ? OP_W : XW;

  logic [LANE_NB*MOD_W-1:0] chk_d;
  logic [LANE_NB*MOD_W-1:0] chk_q [LAT];

  always_comb begin
    chk_d = '0;
    for (int i = 0; i < LANE_NB; i++)
      chk_d[i*MOD_W +: MOD_W] =
        MOD_W'(CW'(a[i*OP_W +: OP_W]) % CW'(M_C));
  end

  always_ff @(posedge clk) begin
    chk_q[0] <= chk_d;
    for (int i = 1; i < LAT; i++)
      chk_q[i] <= chk_q[i-1];
    if (out_avail && (z !== chk_q[LAT-1]))
      $error("reducer z=%h ref=%h", z, chk_q[LAT-1]);
  end

  initial begin
    if (MOD_W < 8 || MOD_W > 64)
      $error("MOD_W=%0d illegal", MOD_W);
    if (MOD_K < 1 || MOD_K > MOD_W / 2)
      $error("MOD_K=%0d illegal", MOD_K);
    if (OP_W > 2 * MOD_W + 1 || OP_W < 1)
      $error("OP_W=%0d illegal", OP_W);
    if (LANE_NB < 1)
      $error("LANE_NB=%0d illegal", LANE_NB);
    if (IN_PIPE != 0 && IN_PIPE != 1)
      $error("IN_PIPE=%0d illegal", IN_PIPE);
    if (SIDE_W < 0)
      $error("SIDE_W=%0d illegal", SIDE_W);
  end
`endif

endmodule
